game_state_ctrl: RTL and testbench

//  Parametrised top-level game FSM for the penalty simulator. It sits between the mouse/UART

---
 rtl/game_state_ctrl.sv | 157 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Penalty-game top FSM: mode select, link-settle gate, turn counter, sync TX byte; all outputs registered.
// Define AUTO_RETURN_EN to leave WINNER/LOSER automatically after HOLD_CYCLES without a click.
package game_pkg;
    typedef enum logic [2:0] {
        START   = 3'd0,
        KEEPER  = 3'd1,
        SHOOTER = 3'd2,
        WINNER  = 3'd3,
        LOSER   = 3'd4
    } g_state;
    typedef enum logic {
        MULTI = 1'b0,
        SOLO  = 1'b1
    } g_mode;
endpackage

module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned SYNC_CYCLES = 1_000_000,
    parameter int unsigned SYNC_W      = 21,
    parameter int unsigned RND_W       = 5,
    parameter int unsigned HOLD_CYCLES = 65_000_000,
    parameter int unsigned HOLD_W      = 27,
    parameter logic [7:0]  TX_LEFT     = 8'hC8,
    parameter logic [7:0]  TX_RIGHT    = 8'h28,
    parameter logic [7:0]  TX_START    = 8'h48,
    parameter logic [7:0]  TX_IDLE     = 8'h08
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left_clicked,
    input  logic             right_clicked,
    input  logic             solo_enable,
    input  logic             connect_corrected,
    input  logic             enemy_shooter,
    input  logic             game_starts,
    input  logic             match_end,
    input  logic             match_result,
    input  logic             end_gk,
    input  logic             end_sh,
    input  logic             back_to_start,
    output logic [7:0]       data_to_transmit,
    output g_state           game_state,
    output g_mode            game_mode,
    output logic [RND_W-1:0] round_cnt,
    output logic             state_changed
);
    localparam logic [SYNC_W-1:0] SYNC_MAX = SYNC_W'(SYNC_CYCLES);

    g_state            next_state;
    g_state            prev_state;
    logic              solo;
    logic              settled;
    logic              round_inc;
    logic              hold_done;
    logic [SYNC_W-1:0] settle_cnt;

`ifdef AUTO_RETURN_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    logic [HOLD_W-1:0] hold_cnt;
    assign hold_done = (hold_cnt == HOLD_LAST);
`else
    // No timer in this build; the expression only keeps the hold parameters referenced and is always 0.
    assign hold_done = (HOLD_W == 0) && (HOLD_CYCLES == 0);
`endif

    // In START the switch decides the mode immediately, so a click in the same cycle is honoured.
    always_comb begin
        solo       = (game_state == START) ? solo_enable : (game_mode == SOLO);
        settled    = (settle_cnt == SYNC_MAX);
        next_state = game_state;
        round_inc  = 1'b0;
        if (!solo && !connect_corrected) begin
            next_state = START;
        end else begin
            case (game_state)
                START: begin
                    if (solo) begin
                        if (left_clicked) next_state = KEEPER;
                    end else if (settled && game_starts) begin
                        next_state = enemy_shooter ? SHOOTER : KEEPER;
                    end
                end
                KEEPER: begin
                    if (match_end) begin
                        next_state = match_result ? WINNER : LOSER;
                        round_inc  = solo;
                    end else if (!solo && end_gk) begin
                        next_state = SHOOTER;
                        round_inc  = 1'b1;
                    end
                end
                SHOOTER: begin
                    if (solo) begin
                        next_state = START;
                    end else if (match_end) begin
                        next_state = match_result ? WINNER : LOSER;
                    end else if (end_sh) begin
                        next_state = KEEPER;
                        round_inc  = 1'b1;
                    end
                end
                WINNER, LOSER: begin
                    if (right_clicked || back_to_start || hold_done) next_state = START;
                end
                default: next_state = START;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            game_state       <= START;
            prev_state       <= START;
            game_mode        <= MULTI;
            data_to_transmit <= 8'h00;
            round_cnt        <= '0;
            state_changed    <= 1'b0;
            settle_cnt       <= '0;
`ifdef AUTO_RETURN_EN
            hold_cnt         <= '0;
`endif
        end else begin
            game_state    <= next_state;
            prev_state    <= game_state;
            state_changed <= (game_state != prev_state);
            if (game_state == START) game_mode <= solo_enable ? SOLO : MULTI;

            if (next_state == START) begin
                round_cnt <= '0;
            end else if (round_inc && !(&round_cnt)) begin
                round_cnt <= round_cnt + 1'b1;
            end

            if (!solo && connect_corrected && (game_state == START)) begin
                if (!settled) settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end

`ifdef AUTO_RETURN_EN
            if (((game_state == WINNER) || (game_state == LOSER)) &&
                ((next_state == WINNER) || (next_state == LOSER))) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
`endif

            if (left_clicked)       data_to_transmit <= TX_LEFT;
            else if (right_clicked) data_to_transmit <= TX_RIGHT;
            else if (game_starts)   data_to_transmit <= TX_START;
            else                    data_to_transmit <= TX_IDLE;
        end
    end
endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed + randomized bench for game_state_ctrl against a rule-level reference model.
module tb_game_state_ctrl;
    import game_pkg::*;

    localparam int SYNC = 8;
    localparam int HOLD = 16;
    localparam int RW   = 3;
    localparam int RMAX = (1 << RW) - 1;
    localparam int S_START = 0, S_KEEP = 1, S_SHOOT = 2, S_WIN = 3, S_LOSE = 4;
`ifdef AUTO_RETURN_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, left_clicked, right_clicked, solo_enable, connect_corrected, enemy_shooter;
    logic game_starts, match_end, match_result, end_gk, end_sh, back_to_start;
    logic [7:0]    data_to_transmit;
    g_state        game_state;
    g_mode         game_mode;
    logic [RW-1:0] round_cnt;
    logic          state_changed;

    game_state_ctrl #(
        .SYNC_CYCLES(SYNC), .SYNC_W(4), .RND_W(RW), .HOLD_CYCLES(HOLD), .HOLD_W(5)
    ) dut (
        .clk(clk), .rst(rst), .left_clicked(left_clicked), .right_clicked(right_clicked),
        .solo_enable(solo_enable), .connect_corrected(connect_corrected),
        .enemy_shooter(enemy_shooter), .game_starts(game_starts), .match_end(match_end),
        .match_result(match_result), .end_gk(end_gk), .end_sh(end_sh),
        .back_to_start(back_to_start), .data_to_transmit(data_to_transmit),
        .game_state(game_state), .game_mode(game_mode), .round_cnt(round_cnt),
        .state_changed(state_changed)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: abstract state numbers, cycle counts and turn tally.
    int       m_state, m_prev, m_settle, m_hold, m_round;
    bit       m_solo, m_chg;
    logic [7:0] m_tx;

    function automatic g_state to_dut(input int s);
        case (s)
            S_KEEP:  return KEEPER;
            S_SHOOT: return SHOOTER;
            S_WIN:   return WINNER;
            S_LOSE:  return LOSER;
            default: return START;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit solo, inc, fin;
        int nxt;
        if (!rst) begin
            m_state = S_START; m_prev = S_START; m_solo = 0; m_chg = 0;
            m_settle = 0; m_hold = 0; m_round = 0; m_tx = 8'h00;
            return;
        end
        solo = (m_state == S_START) ? solo_enable : m_solo;
        fin  = right_clicked || back_to_start || (AUTO && m_hold == HOLD - 1);
        nxt  = m_state;
        inc  = 0;
        if (!solo && !connect_corrected) nxt = S_START;
        else if (m_state == S_START) begin
            if (solo && left_clicked) nxt = S_KEEP;
            else if (!solo && game_starts && m_settle >= SYNC) nxt = enemy_shooter ? S_SHOOT : S_KEEP;
        end else if (m_state == S_WIN || m_state == S_LOSE) begin
            if (fin) nxt = S_START;
        end else if (solo && m_state == S_SHOOT) nxt = S_START;
        else if (match_end) begin
            nxt = match_result ? S_WIN : S_LOSE;
            inc = solo;
        end else if (!solo && m_state == S_KEEP && end_gk) begin
            nxt = S_SHOOT; inc = 1;
        end else if (!solo && m_state == S_SHOOT && end_sh) begin
            nxt = S_KEEP; inc = 1;
        end
        m_settle = (!solo && connect_corrected && m_state == S_START) ?
                   ((m_settle < SYNC) ? m_settle + 1 : SYNC) : 0;
        m_hold   = ((m_state == S_WIN || m_state == S_LOSE) && (nxt == S_WIN || nxt == S_LOSE)) ?
                   m_hold + 1 : 0;
        m_round  = (nxt == S_START) ? 0 : ((inc && m_round < RMAX) ? m_round + 1 : m_round);
        if (m_state == S_START) m_solo = solo_enable;
        m_tx = left_clicked ? 8'hC8 : right_clicked ? 8'h28 : game_starts ? 8'h48 : 8'h08;
        m_chg   = (m_state != m_prev);
        m_prev  = m_state;
        m_state = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state", 32'(game_state), 32'(to_dut(m_state)));
        chk("mode", 32'(game_mode), 32'(m_solo ? SOLO : MULTI));
        chk("tx", 32'(data_to_transmit), 32'(m_tx));
        chk("round", 32'(round_cnt), 32'(m_round));
        chk("chg", 32'(state_changed), 32'(m_chg));
    endtask

    task automatic clear_pulses();
        left_clicked = 0; right_clicked = 0; game_starts = 0; match_end = 0;
        match_result = 0; end_gk = 0; end_sh = 0; back_to_start = 0;
    endtask

    initial begin
        rst = 0; solo_enable = 0; connect_corrected = 0; enemy_shooter = 0;
        clear_pulses();

        // Reset values
        tick(); tick();
        chk("rst_state", 32'(game_state), 32'(START));
        chk("rst_mode", 32'(game_mode), 32'(MULTI));
        chk("rst_tx", 32'(data_to_transmit), 32'h00);
        chk("rst_round", 32'(round_cnt), 32'd0);
        chk("rst_chg", 32'(state_changed), 32'd0);
        rst = 1;

        // SOLO match
        solo_enable = 1; tick();
        chk("solo_mode", 32'(game_mode), 32'(SOLO));
        left_clicked = 1; tick(); clear_pulses();
        chk("solo_keeper", 32'(game_state), 32'(KEEPER));
        chk("solo_chg_lag", 32'(state_changed), 32'd0);
        tick();
        chk("solo_chg_pulse", 32'(state_changed), 32'd1);
        tick();
        chk("solo_chg_end", 32'(state_changed), 32'd0);
        match_end = 1; match_result = 1; tick(); clear_pulses();
        chk("solo_winner", 32'(game_state), 32'(WINNER));
        chk("solo_round", 32'(round_cnt), 32'd1);
        right_clicked = 1; tick(); clear_pulses();
        chk("solo_back", 32'(game_state), 32'(START));
        chk("solo_round_clr", 32'(round_cnt), 32'd0);
        chk("tx_right", 32'(data_to_transmit), 32'h28);

        // MULTI settle gate
        solo_enable = 0; connect_corrected = 0; tick();
        connect_corrected = 1; enemy_shooter = 1;
        for (int i = 0; i < 10; i++) begin
            game_starts = (i == 5 || i == 9);
            tick();
            if (i == 5) chk("early_start_ignored", 32'(game_state), 32'(START));
        end
        game_starts = 0;
        chk("sync_shooter", 32'(game_state), 32'(SHOOTER));

        // Turn alternation, simultaneous end, saturation, link drop
        for (int i = 0; i < 3; i++) begin
            if (i % 2 == 0) end_sh = 1; else end_gk = 1;
            tick(); clear_pulses();
        end
        chk("round3", 32'(round_cnt), 32'd3);
        match_end = 1; match_result = 0; end_gk = 1; tick(); clear_pulses();
        chk("loser", 32'(game_state), 32'(LOSER));
        chk("loser_round", 32'(round_cnt), 32'd3);
        back_to_start = 1; tick(); clear_pulses();
        chk("bts_start", 32'(game_state), 32'(START));
        repeat (9) tick();
        enemy_shooter = 0; game_starts = 1; tick(); clear_pulses();
        chk("sync_keeper", 32'(game_state), 32'(KEEPER));
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) end_gk = 1; else end_sh = 1;
            tick(); clear_pulses();
        end
        chk("round_sat", 32'(round_cnt), 32'(RMAX));
        chk("after_sat_keeper", 32'(game_state), 32'(KEEPER));
        connect_corrected = 0; tick();
        chk("link_drop", 32'(game_state), 32'(START));
        chk("link_drop_round", 32'(round_cnt), 32'd0);

        // TX priority
        left_clicked = 1; right_clicked = 1; game_starts = 1; tick(); clear_pulses();
        chk("tx_left", 32'(data_to_transmit), 32'hC8);
        game_starts = 1; tick(); clear_pulses();
        chk("tx_start", 32'(data_to_transmit), 32'h48);
        tick();
        chk("tx_idle", 32'(data_to_transmit), 32'h08);

        // End-screen hold
        solo_enable = 1; tick();
        left_clicked = 1; tick(); clear_pulses();
        match_end = 1; match_result = 1; tick(); clear_pulses();
        chk("hold_enter", 32'(game_state), 32'(WINNER));
        repeat (HOLD - 1) tick();
        chk("hold_still", 32'(game_state), 32'(WINNER));
        tick();
        chk("hold_expire", 32'(game_state), 32'(AUTO ? START : WINNER));
        right_clicked = 1; tick(); clear_pulses();
        solo_enable = 0; connect_corrected = 1;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst               = ($urandom_range(0, 299) != 0);
            left_clicked      = ($urandom_range(0, 99) < 5);
            right_clicked     = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 3) solo_enable = ~solo_enable;
            connect_corrected = ($urandom_range(0, 99) < 97);
            enemy_shooter     = 1'($urandom);
            game_starts       = ($urandom_range(0, 99) < 10);
            match_end         = ($urandom_range(0, 99) < 4);
            match_result      = 1'($urandom);
            end_gk            = ($urandom_range(0, 99) < 20);
            end_sh            = ($urandom_range(0, 99) < 20);
            back_to_start     = ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
